bitfield_issue_ctrl: RTL and testbench
======================================

Name: bitfield_issue_ctrl

Overview:
- Shares one bitfield datapath (set/clr/chg/ins/insi/ext/extu/ffo ops, 40-bit instruction, DWIDTH-bit operands) among NREQ issue requesters.
- Round-robin arbiter feeds a two-stage pipeline: an operand-capture register, then a result holding register.
- The result register drives the result bus with a valid/ack handshake, backpressure and flush.
- Sits between the issue queue slots and the common result bus.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DWIDTH, 80, operand/result width.
- TAGW, 6, result tag width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; held with operands until granted.
- gnt  output  NREQ  one-hot grant; combinational; transfer occurs when req[i]&gnt[i].
- inst_i  input  NREQ*40  per-requester instruction word; slice i = bits [40i+39:40i].
- a_i, b_i, c_i  input  NREQ*DWIDTH each  per-requester operands a, b, c.
- tag_i  input  NREQ*TAGW  per-requester destination tag.
- flush  input  1  cancels all in-flight ops (branch miss).
- o_v  output  1  result valid.
- o_res  output  DWIDTH  result.
- o_mask  output  DWIDTH  field mask produced with the result.
- o_tag  output  TAGW  tag of the result.
- o_exc  output  1  illegal-opcode flag.
- o_ack  input  1  result bus accepted o_* this cycle.
- busy  output  1  s1_v | o_v.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - s1_v=0, o_v=0, o_res=0, o_mask=0, o_tag=0, o_exc=0.
  - Arbiter pointer last=NREQ-1, so requester 0 has top priority first.
  - gnt=0 while rst=1.
  - rst asserted mid-operation drops all ops; no result is presented.
- Stage advance:
  - s2_free = !o_v | o_ack.
  - s1_adv = s1_v & s2_free.
  - accept = !flush & (!s1_v | s1_adv).
- Arbitration:
  - When accept=1, gnt selects the first asserted req at indices last+1, last+2, ... (mod NREQ).
  - When accept=0, gnt=0.
  - On a grant, last<=granted index. last is unchanged when no grant.
- Stage 1: on a grant, capture inst, a, b, c, tag of the winner and set s1_v=1. Otherwise s1_v<=s1_v & !s1_adv.
- Datapath: the bitfield datapath is instanced combinationally on the stage-1 registers. Its result and mask are registered into stage 2.
- Stage 2:
  - On s1_adv, o_res, o_mask and o_tag load and o_v<=1.
  - Else if o_ack, o_v<=0.
  - o_* hold stable while o_v & !o_ack.
- Latency: grant in cycle N -> o_v=1 in cycle N+2 when unstalled. Throughput is 1 op/cycle with o_ack held high.
- Illegal opcode: opcode = inst[39:36] in {7, 9..15}.
  - o_exc=1 and o_res=0. o_mask is still loaded.
  - The op still completes and is acknowledged normally.
- Full: with s1_v=1, o_v=1 and o_ack=0, gnt=0; the requester keeps req asserted.
- Flush (highest priority after rst):
  - Next cycle s1_v=0 and o_v=0.
  - No grant in the flush cycle.
  - An o_ack coinciding with flush is ignored; the result is discarded.
- Simultaneous o_ack and s1_adv: the new result replaces the old one and o_v stays 1.
- Widths: all slice selects use explicit index arithmetic; no truncation of DWIDTH operands.

Test Plan:
- Reset: hold rst 2 cycles with req=2'b11 -> gnt=0, o_v=0, busy=0. First grant after reset is gnt=2'b01.
- Extract: req0, inst op=6 (BFEXTU) with bits 35/34/33=1, a=8, b=7, c=0x12345678, tag=5.
  - gnt=01 in cycle N.
  - Cycle N+2: o_v=1, o_res=0x56, o_mask=0xFF00, o_tag=5, o_exc=0.
- Round-robin: req=11 held 4 cycles with o_ack=1 -> gnt sequence 01,10,01,10. Results appear 2 cycles later in the same order.
- Backpressure: o_ack=0 after the first result.
  - Second op fills stage 1; gnt=0 from then on.
  - o_res unchanged for 5 cycles.
  - Raising o_ack drains one result per cycle with no loss or duplication.
- Flush: with s1_v=1, o_v=1 and req0 asserted, pulse flush -> gnt=0 that cycle; next cycle o_v=0, busy=0; the held req0 is granted the cycle after.
- Illegal op: op=4'd7 -> o_v=1 two cycles after grant, o_exc=1, o_res=0. A following legal op has o_exc=0.

Source files
------------

// File: rtl/bitfield_issue_ctrl.sv
// Bitfield issue controller: round-robin arbiter in front of a two-stage
// pipeline (operand capture, then result hold) that shares one bitfield
// datapath among several issue-queue requesters.
//
// Instruction word layout:
//   [39:36] opcode   0 SET, 1 CLR, 2 CHG, 3 INS, 4 INSI, 5 EXT, 6 EXTU, 8 FFO
//   [35]    field offset taken from a[6:0] (else immediate [19:13])
//   [34]    field width-1 taken from b[6:0] (else immediate [12:6])
//   [33]    source/base operand is c (else a)
//   [31:20] INSI immediate (zero-extended)
// mask = (width ones) << offset. SET/CLR/CHG/INS/INSI modify the base in
// place. EXT/EXTU right-justify the field with sign or zero extension.
// FFO returns the index of the most significant set bit of the base, or
// DWIDTH when the base is zero.
module bitfield_issue_ctrl #(
    parameter int NREQ   = 2,
    parameter int DWIDTH = 80,
    parameter int TAGW   = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    input  logic [NREQ*40-1:0]       inst_i,
    input  logic [NREQ*DWIDTH-1:0]   a_i,
    input  logic [NREQ*DWIDTH-1:0]   b_i,
    input  logic [NREQ*DWIDTH-1:0]   c_i,
    input  logic [NREQ*TAGW-1:0]     tag_i,
    input  logic                     flush,
    output logic                     o_v,
    output logic [DWIDTH-1:0]        o_res,
    output logic [DWIDTH-1:0]        o_mask,
    output logic [TAGW-1:0]          o_tag,
    output logic                     o_exc,
    input  logic                     o_ack,
    output logic                     busy
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

    typedef enum logic [3:0] {
        OP_SET  = 4'd0,
        OP_CLR  = 4'd1,
        OP_CHG  = 4'd2,
        OP_INS  = 4'd3,
        OP_INSI = 4'd4,
        OP_EXT  = 4'd5,
        OP_EXTU = 4'd6,
        OP_FFO  = 4'd8
    } op_e;

    logic [LW-1:0]     last_q, last_d;
    logic              s1_v_q, s1_v_d;
    logic [39:0]       s1_inst_q, s1_inst_d;
    logic [DWIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
    logic [TAGW-1:0]   s1_tag_q, s1_tag_d;
    logic              o_v_q, o_v_d;
    logic [DWIDTH-1:0] o_res_q, o_res_d, o_mask_q, o_mask_d;
    logic [TAGW-1:0]   o_tag_q, o_tag_d;
    logic              o_exc_q, o_exc_d;

    logic              s2_free, s1_adv, accept;
    logic              win_found;
    logic [LW-1:0]     win_idx;
    logic [DWIDTH-1:0] dp_res, dp_mask;
    logic              dp_exc;
    logic              unused_inst;

    assign unused_inst = ^{s1_inst_q[32], s1_inst_q[5:0]};

    // Pipeline handshake: stage 2 frees when empty or acked; flush and reset block new grants.
    always_comb begin
        s2_free = !o_v_q | o_ack;
        s1_adv  = s1_v_q & s2_free;
        accept  = !rst & !flush & (!s1_v_q | s1_adv);
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        gnt       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && req[(int'(last_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = LW'((int'(last_q) + k) % NREQ);
            end
        end
        if (accept && win_found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // Stage 1 capture of the winning requester's instruction, operands and tag.
    always_comb begin
        last_d    = last_q;
        s1_v_d    = s1_v_q & !s1_adv;
        s1_inst_d = s1_inst_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_c_d    = s1_c_q;
        s1_tag_d  = s1_tag_q;
        if (|gnt) begin
            last_d    = win_idx;
            s1_v_d    = 1'b1;
            s1_inst_d = inst_i[int'(win_idx) * 40 +: 40];
            s1_a_d    = a_i[int'(win_idx) * DWIDTH +: DWIDTH];
            s1_b_d    = b_i[int'(win_idx) * DWIDTH +: DWIDTH];
            s1_c_d    = c_i[int'(win_idx) * DWIDTH +: DWIDTH];
            s1_tag_d  = tag_i[int'(win_idx) * TAGW +: TAGW];
        end
        if (flush) begin
            s1_v_d = 1'b0;
        end
    end

    // Bitfield datapath evaluated on the stage-1 registers.
    always_comb begin
        logic [6:0]        offset;
        logic [6:0]        wm1;
        logic [7:0]        wcnt;
        logic [DWIDTH-1:0] src, low, field, topbit, ins_val;
        int                ffo_idx;
        op_e               op;
        op      = op_e'(s1_inst_q[39:36]);
        offset  = s1_inst_q[35] ? s1_a_q[6:0] : s1_inst_q[19:13];
        wm1     = s1_inst_q[34] ? s1_b_q[6:0] : s1_inst_q[12:6];
        wcnt    = {1'b0, wm1} + 8'd1;
        src     = s1_inst_q[33] ? s1_c_q : s1_a_q;
        low     = ~({DWIDTH{1'b1}} << wcnt);
        dp_mask = low << offset;
        field   = (src >> offset) & low;
        topbit  = low & ~(low >> 1);
        ins_val = (op == OP_INSI) ? DWIDTH'(s1_inst_q[31:20]) : s1_b_q;
        ffo_idx = DWIDTH;
        for (int i = 0; i < DWIDTH; i++) begin
            if (src[i]) begin
                ffo_idx = i;
            end
        end
        dp_exc = 1'b0;
        dp_res = '0;
        case (op)
            OP_SET:          dp_res = src | dp_mask;
            OP_CLR:          dp_res = src & ~dp_mask;
            OP_CHG:          dp_res = src ^ dp_mask;
            OP_INS, OP_INSI: dp_res = (src & ~dp_mask) | ((ins_val << offset) & dp_mask);
            OP_EXT:          dp_res = (|(field & topbit)) ? (field | ~low) : field;
            OP_EXTU:         dp_res = field;
            OP_FFO:          dp_res = DWIDTH'(ffo_idx);
            default:         dp_exc = 1'b1;
        endcase
    end

    // Stage 2 result holding register with valid/ack handshake.
    always_comb begin
        o_v_d    = o_v_q;
        o_res_d  = o_res_q;
        o_mask_d = o_mask_q;
        o_tag_d  = o_tag_q;
        o_exc_d  = o_exc_q;
        if (s1_adv) begin
            o_v_d    = 1'b1;
            o_res_d  = dp_exc ? '0 : dp_res;
            o_mask_d = dp_mask;
            o_tag_d  = s1_tag_q;
            o_exc_d  = dp_exc;
        end else if (o_ack) begin
            o_v_d = 1'b0;
        end
        if (flush) begin
            o_v_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= LAST_RST;
            s1_v_q    <= 1'b0;
            s1_inst_q <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_c_q    <= '0;
            s1_tag_q  <= '0;
            o_v_q     <= 1'b0;
            o_res_q   <= '0;
            o_mask_q  <= '0;
            o_tag_q   <= '0;
            o_exc_q   <= 1'b0;
        end else begin
            last_q    <= last_d;
            s1_v_q    <= s1_v_d;
            s1_inst_q <= s1_inst_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_c_q    <= s1_c_d;
            s1_tag_q  <= s1_tag_d;
            o_v_q     <= o_v_d;
            o_res_q   <= o_res_d;
            o_mask_q  <= o_mask_d;
            o_tag_q   <= o_tag_d;
            o_exc_q   <= o_exc_d;
        end
    end

    assign o_v    = o_v_q;
    assign o_res  = o_res_q;
    assign o_mask = o_mask_q;
    assign o_tag  = o_tag_q;
    assign o_exc  = o_exc_q;
    assign busy   = s1_v_q | o_v_q;

endmodule

// File: tb/tb_bitfield_issue_ctrl.sv
// Testbench for bitfield_issue_ctrl: table of hand-computed bitfield ops
// plus directed arbitration, backpressure, flush and reset sequences.
// Results are checked in order against a scoreboard queue.
module tb_bitfield_issue_ctrl;
    localparam int NREQ = 2;
    localparam int DW   = 80;
    localparam int TW   = 6;
    localparam int NVEC = 15;

    typedef struct {
        logic [39:0]   inst;
        logic [DW-1:0] a, b, c;
        logic [TW-1:0] tag;
        logic [DW-1:0] res, mask;
        logic          exc;
    } vec_t;

    typedef struct {
        logic [DW-1:0] res, mask;
        logic [TW-1:0] tag;
        logic          exc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      gnt;
    logic [NREQ*40-1:0]   inst_i;
    logic [NREQ*DW-1:0]   a_i, b_i, c_i;
    logic [NREQ*TW-1:0]   tag_i;
    logic                 flush;
    logic                 o_v;
    logic [DW-1:0]        o_res, o_mask;
    logic [TW-1:0]        o_tag;
    logic                 o_exc;
    logic                 o_ack;
    logic                 busy;

    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];
    vec_t vecs[NVEC];

    bitfield_issue_ctrl #(.NREQ(NREQ), .DWIDTH(DW), .TAGW(TW)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .inst_i(inst_i), .a_i(a_i), .b_i(b_i), .c_i(c_i), .tag_i(tag_i),
        .flush(flush), .o_v(o_v), .o_res(o_res), .o_mask(o_mask),
        .o_tag(o_tag), .o_exc(o_exc), .o_ack(o_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] mk(input logic [3:0] op, input logic fa, input logic fb,
                                       input logic fc, input logic [11:0] imm,
                                       input logic [6:0] off, input logic [6:0] wm1);
        mk = {op, fa, fb, fc, 1'b0, imm, off, wm1, 6'd0};
    endfunction

    function automatic vec_t mkv(input logic [39:0] inst, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [DW-1:0] c,
                                 input logic [TW-1:0] tag, input logic [DW-1:0] res,
                                 input logic [DW-1:0] mask, input logic exc);
        mkv.inst = inst; mkv.a = a; mkv.b = b; mkv.c = c; mkv.tag = tag;
        mkv.res = res; mkv.mask = mask; mkv.exc = exc;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic loadReq(input int r, input vec_t v);
        inst_i[r*40 +: 40] = v.inst;
        a_i[r*DW +: DW]    = v.a;
        b_i[r*DW +: DW]    = v.b;
        c_i[r*DW +: DW]    = v.c;
        tag_i[r*TW +: TW]  = v.tag;
    endtask

    task automatic pushExp(input vec_t v);
        exp_t e;
        e.res = v.res; e.mask = v.mask; e.tag = v.tag; e.exc = v.exc;
        sbq.push_back(e);
    endtask

    // Issue one op on requester 0 (called at a negedge), waiting a bounded time for the grant.
    task automatic applyStimulus(input vec_t v);
        bit granted = 0;
        loadReq(0, v);
        req[0] = 1'b1;
        for (int n = 0; n < 20 && !granted; n++) begin
            #1;
            if (gnt[0]) begin
                granted = 1;
                pushExp(v);
            end
            @(negedge clk);
        end
        req[0] = 1'b0;
        if (!granted) checkOutput("grant_timeout", 0, 1);
    endtask

    // Wait (bounded) until the pipeline is empty and all expected results were seen.
    task automatic drain();
        int n = 0;
        while ((busy || sbq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("drain_timeout", DW'(sbq.size()), 0);
        @(negedge clk);
    endtask

    // Result monitor: every accepted result is popped from the scoreboard and compared.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && !flush && o_v && o_ack) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_result", o_res, 'x);
            end else begin
                e = sbq.pop_front();
                checkOutput("res",  o_res,  e.res);
                checkOutput("mask", o_mask, e.mask);
                checkOutput("tag",  DW'(o_tag), DW'(e.tag));
                checkOutput("exc",  DW'(o_exc), DW'(e.exc));
            end
        end
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t x, y, z;
        vecs[0]  = mkv(mk(4'd6, 1, 1, 1, 12'h0, 7'd0, 7'd0), 'd8, 'd7, 'h12345678, 6'd5, 'h56, 'hFF00, 0);
        vecs[1]  = mkv(mk(4'd0, 0, 0, 1, 12'h0, 7'd4, 7'd3), 0, 0, 0, 6'd1, 'hF0, 'hF0, 0);
        vecs[2]  = mkv(mk(4'd1, 0, 0, 1, 12'h0, 7'd0, 7'd7), 0, 0, 'h1234, 6'd2, 'h1200, 'hFF, 0);
        vecs[3]  = mkv(mk(4'd2, 0, 0, 1, 12'h0, 7'd8, 7'd3), 0, 0, 'hA00, 6'd3, 'h500, 'hF00, 0);
        vecs[4]  = mkv(mk(4'd3, 0, 0, 1, 12'h0, 7'd4, 7'd7), 0, 'hAB, 'hFFFF, 6'd4, 'hFABF, 'hFF0, 0);
        vecs[5]  = mkv(mk(4'd4, 0, 0, 1, 12'h123, 7'd16, 7'd11), 0, 0, 0, 6'd6, 'h1230000, 'hFFF0000, 0);
        vecs[6]  = mkv(mk(4'd5, 0, 0, 1, 12'h0, 7'd0, 7'd7), 0, 0, 'h80, 6'd7, {{72{1'b1}}, 8'h80}, 'hFF, 0);
        vecs[7]  = mkv(mk(4'd5, 0, 0, 1, 12'h0, 7'd0, 7'd7), 0, 0, 'h7F, 6'd8, 'h7F, 'hFF, 0);
        vecs[8]  = mkv(mk(4'd8, 0, 0, 1, 12'h0, 7'd0, 7'd0), 0, 0, 'h100, 6'd9, 'd8, 'h1, 0);
        vecs[9]  = mkv(mk(4'd8, 0, 0, 1, 12'h0, 7'd0, 7'd0), 0, 0, 0, 6'd10, 'd80, 'h1, 0);
        vecs[10] = mkv(mk(4'd7, 0, 0, 1, 12'h0, 7'd0, 7'd0), 0, 0, 'hFFFF, 6'd11, 0, 'h1, 1);
        vecs[11] = mkv(mk(4'd0, 0, 0, 0, 12'h0, 7'd0, 7'd0), 'h10, 0, 0, 6'd12, 'h11, 'h1, 0);
        vecs[12] = mkv(mk(4'd15, 0, 0, 1, 12'h0, 7'd4, 7'd3), 0, 0, 'h55, 6'd13, 0, 'hF0, 1);
        vecs[13] = mkv(mk(4'd0, 0, 0, 1, 12'h0, 7'd0, 7'd79), 0, 0, 0, 6'd14, {DW{1'b1}}, {DW{1'b1}}, 0);
        vecs[14] = mkv(mk(4'd6, 0, 0, 1, 12'h0, 7'd72, 7'd7), 0, 0, {8'hAB, 72'h0}, 6'd15, 'hAB, {8'hFF, 72'h0}, 0);

        rst = 1'b1; req = '1; flush = 1'b0; o_ack = 1'b1;
        inst_i = '0; a_i = '0; b_i = '0; c_i = '0; tag_i = '0;

        // Reset with both requests pending.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_gnt", DW'(gnt), 0);
        checkOutput("rst_o_v", DW'(o_v), 0);
        checkOutput("rst_busy", DW'(busy), 0);
        checkOutput("rst_o_res", o_res, 0);
        checkOutput("rst_o_mask", o_mask, 0);
        checkOutput("rst_o_tag", DW'(o_tag), 0);
        checkOutput("rst_o_exc", DW'(o_exc), 0);

        // Round robin: both held for four cycles, alternating from requester 0.
        @(negedge clk);
        loadReq(0, vecs[0]);
        loadReq(1, vecs[1]);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("rr_gnt%0d", k), DW'(gnt), (k % 2 == 0) ? 'b01 : 'b10);
            pushExp((k % 2 == 0) ? vecs[0] : vecs[1]);
            @(negedge clk);
        end
        req = '0;
        drain();

        // Latency: grant in cycle N, result valid in cycle N+2.
        loadReq(0, vecs[0]);
        req[0] = 1'b1;
        #1;
        checkOutput("lat_gnt", DW'(gnt), 'b01);
        pushExp(vecs[0]);
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        checkOutput("lat_n1_o_v", DW'(o_v), 0);
        @(negedge clk);
        #1;
        checkOutput("lat_n2_o_v", DW'(o_v), 1);
        checkOutput("lat_n2_o_res", o_res, 'h56);
        @(negedge clk);
        drain();

        // Table of single ops, issued back to back.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end
        drain();

        // Backpressure: results held while o_ack is low, then drained in order.
        x = vecs[2]; y = vecs[3]; z = vecs[4];
        o_ack = 1'b0;
        loadReq(0, x);
        req[0] = 1'b1;
        #1;
        checkOutput("bp_gnt_x", DW'(gnt), 'b01);
        pushExp(x);
        @(negedge clk);
        loadReq(0, y);
        #1;
        checkOutput("bp_gnt_y", DW'(gnt), 'b01);
        pushExp(y);
        @(negedge clk);
        loadReq(0, z);
        #1;
        checkOutput("bp_full_gnt", DW'(gnt), 0);
        checkOutput("bp_full_o_v", DW'(o_v), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("bp_hold_gnt%0d", k), DW'(gnt), 0);
            checkOutput($sformatf("bp_hold_res%0d", k), o_res, x.res);
        end
        @(negedge clk);
        o_ack = 1'b1;
        #1;
        checkOutput("bp_release_gnt", DW'(gnt), 'b01);
        pushExp(z);
        @(negedge clk);
        req[0] = 1'b0;
        drain();

        // Flush with both stages full and req0 held; ack in the flush cycle is ignored.
        x = vecs[5]; y = vecs[6]; z = vecs[7];
        o_ack = 1'b0;
        loadReq(0, x);
        req[0] = 1'b1;
        #1;
        checkOutput("fl_gnt_x", DW'(gnt), 'b01);
        pushExp(x);
        @(negedge clk);
        loadReq(0, y);
        #1;
        checkOutput("fl_gnt_y", DW'(gnt), 'b01);
        pushExp(y);
        @(negedge clk);
        loadReq(0, z);
        o_ack = 1'b1;
        flush = 1'b1;
        #1;
        checkOutput("fl_gnt", DW'(gnt), 0);
        sbq.delete();
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("fl_after_o_v", DW'(o_v), 0);
        checkOutput("fl_after_busy", DW'(busy), 0);
        checkOutput("fl_after_gnt", DW'(gnt), 'b01);
        pushExp(z);
        @(negedge clk);
        req[0] = 1'b0;
        drain();

        // Reset while an op is in flight: nothing is presented.
        loadReq(0, vecs[8]);
        req[0] = 1'b1;
        #1;
        checkOutput("mr_gnt", DW'(gnt), 'b01);
        @(negedge clk);
        req[0] = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("mr_rst_gnt", DW'(gnt), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("mr_o_v%0d", k), DW'(o_v), 0);
            checkOutput($sformatf("mr_busy%0d", k), DW'(busy), 0);
            @(negedge clk);
        end

        // One more op after the mid-run reset.
        applyStimulus(vecs[11]);
        drain();
        checkOutput("sb_empty", DW'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
